surf_cout_word_capture: RTL and testbench
=========================================

# surf_cout_word_capture

Parametrised word-assembly and training-check stage for the SURF→TURFIO COUT path. It sits after the COUT PHY's per-clock ISERDES output and assembles IN_WIDTH-bit beats into words aligned to the global sync. No lock search is performed: the PHY is already eye-aligned and bitslipped, and the SURF's sequence is fixed by sync. It adds a training-pattern checker with a saturating error counter, a one-shot hold register, and sync-misalignment detection.

## Interface
- IN_WIDTH, 4: beat width from the PHY; 1..16.
- NBEATS, 8: beats per word, power of two, ≥2; word width W = IN_WIDTH*NBEATS (32 by default).
- TRAIN_PATTERN, 32'hA55A6996: expected word (W bits) in training mode.
- CNT_WIDTH, 16: width of the error counter.
- sysclk_i  in  1  system clock; all logic is on this clock.
- rst_i  in  1  asynchronous active-high reset.
- sync_i  in  1  high marks the cycle whose data_i is beat 0.
- data_i  in  IN_WIDTH  beat from the PHY, new every cycle.
- enable_i  in  1  enables word assembly.
- train_i  in  1  compares completed words against TRAIN_PATTERN.
- capture_i  in  1  arms the one-shot hold register.
- errcnt_clr_i  in  1  clears errcnt_o.
- data_o  out  W  last completed word.
- valid_o  out  1  one-cycle strobe for a new word on data_o.
- hold_o  out  W  captured word.
- hold_valid_o  out  1  hold_o contains a word captured since the last arm.
- biterr_o  out  1  one-cycle strobe: completed word ≠ TRAIN_PATTERN while train_i.
- errcnt_o  out  CNT_WIDTH  saturating count of biterr_o strobes.
- locked_o  out  1  sync seen since enable.
- sync_err_o  out  1  one-cycle strobe: sync arrived with beat counter ≠ 0 while locked.

## Operation
- Beat counter phase, log2(NBEATS) bits.
  - sync_i & enable_i: the current beat is beat 0; phase becomes 1 next cycle; the partial word is discarded.
  - Otherwise, while locked: phase increments modulo NBEATS.
- Ordering: beat 0 is the first beat in time and goes in the MS IN_WIDTH bits (data_o[W-1 -: IN_WIDTH]); the last beat goes in the LSBs.
- Word completion happens when locked_o, or sync_i is high this cycle, and the current beat is beat NBEATS-1. On completion: data_o loads the word, valid_o=1 next cycle, and compare/capture act.
- locked_o:
  - Set at the edge sampling sync_i & enable_i.
  - Cleared while enable_i is low; no words are produced while unlocked. Disabling discards the partial word, and a new sync is required.
- sync_err_o: sync_i while locked_o with current phase ≠ 0. The realignment still takes effect and the truncated word is never emitted. A sync that lands on phase 0 is silent.
- Training: on completion with train_i=1 and word ≠ TRAIN_PATTERN, biterr_o=1.
- errcnt_o:
  - Increments on biterr_o and saturates at all-ones.
  - errcnt_clr_i has priority: if a clear and an error occur in the same cycle, the result is 0.
- Hold register:
  - capture_i sets armed and clears hold_valid_o.
  - The first completion while armed, including a completion in the same cycle as capture_i, loads hold_o, sets hold_valid_o and clears armed.
  - capture_i while already armed is a no-op re-arm.
- Reset values: all outputs 0, phase 0, armed 0, errcnt 0.

## Timing
- Latency: the last beat is presented in cycle k; data_o, valid_o and biterr_o are valid in cycle k+1. errcnt_o and hold_o/hold_valid_o update at the same edge.
- Throughput: one word every NBEATS cycles. valid_o is never high in consecutive cycles (NBEATS≥2).
- The first word after sync in cycle s completes with valid_o in cycle s+NBEATS.
- rst_i mid-word: immediate clear, and a new sync is required. enable_i low mid-word: the partial word is dropped next edge and valid_o stays 0.
- Combinational paths: none from inputs to outputs; all outputs are registered.

## Test plan
- Default params. Reset, then enable_i=1, sync_i in cycle 10, beats 0xA,5,5,A,6,9,9,6 on data_i from cycle 10 -> valid_o only in cycle 18, data_o=32'hA55A6996. With train_i=1: biterr_o=0, errcnt_o=0.
- Train mode, flip one bit in beat 3 of every word for 5 words -> 5 biterr_o strobes, errcnt_o=5. Then assert errcnt_clr_i in the same cycle as a 6th error -> errcnt_o=0.
- CNT_WIDTH=2, 5 error words -> errcnt_o saturates at 3.
- Locked, resync at phase 3 -> sync_err_o pulse and no word emitted for the truncated word. The next word completes NBEATS cycles after the resync. A resync landing at phase 0 -> no sync_err_o.
- Pulse capture_i in the completion cycle -> that word is in hold_o and hold_valid_o=1. A later word does not overwrite it. A new capture_i clears hold_valid_o until the next completion.
- Drop enable_i mid-word, then assert rst_i mid-word -> valid_o stays 0 and locked_o=0. Words resume only after a new sync.

Source files
------------

// File: rtl/surf_cout_word_capture_if.sv
// surf_cout_word_capture_if: COUT beat input, control and assembled-word outputs
interface surf_cout_word_capture_if #(
  parameter int IN_WIDTH  = 4,
  parameter int NBEATS    = 8,
  parameter int CNT_WIDTH = 16
);
  localparam int W = IN_WIDTH * NBEATS;
  logic                 sync_i;
  logic [IN_WIDTH-1:0]  data_i;
  logic                 enable_i;
  logic                 train_i;
  logic                 capture_i;
  logic                 errcnt_clr_i;
  logic [W-1:0]         data_o;
  logic                 valid_o;
  logic [W-1:0]         hold_o;
  logic                 hold_valid_o;
  logic                 biterr_o;
  logic [CNT_WIDTH-1:0] errcnt_o;
  logic                 locked_o;
  logic                 sync_err_o;
  modport master (
    output sync_i, data_i, enable_i, train_i, capture_i, errcnt_clr_i,
    input  data_o, valid_o, hold_o, hold_valid_o, biterr_o, errcnt_o, locked_o, sync_err_o
  );
  modport slave (
    input  sync_i, data_i, enable_i, train_i, capture_i, errcnt_clr_i,
    output data_o, valid_o, hold_o, hold_valid_o, biterr_o, errcnt_o, locked_o, sync_err_o
  );
endinterface

// File: rtl/surf_cout_word_capture.sv
// surf_cout_word_capture: sync-aligned word assembly with training check and one-shot hold
module surf_cout_word_capture #(
  parameter int                         IN_WIDTH      = 4,
  parameter int                         NBEATS        = 8,
  parameter logic [IN_WIDTH*NBEATS-1:0] TRAIN_PATTERN = 32'hA55A6996,
  parameter int                         CNT_WIDTH     = 16
) (
  input logic                   sysclk_i,
  input logic                   rst_i,
  surf_cout_word_capture_if.slave cout
);
  localparam int W  = IN_WIDTH * NBEATS;
  localparam int PW = $clog2(NBEATS);
  logic [PW-1:0]         phase;
  logic [W-IN_WIDTH-1:0] sr;
  logic [W-1:0]          word;
  logic                  armed, resync, done, miss;
  // the shifter always holds the previous NBEATS-1 beats, so a sync needs no explicit flush
  always_comb begin
    resync = cout.sync_i & cout.enable_i;
    word   = {sr, cout.data_i};
    done   = cout.enable_i & (cout.locked_o | cout.sync_i) &
             ((resync ? PW'(0) : phase) == PW'(NBEATS - 1));
    miss   = done & cout.train_i & (word != TRAIN_PATTERN);
  end
  always_ff @(posedge sysclk_i or posedge rst_i) begin
    if (rst_i) begin
      phase             <= '0;
      sr                <= '0;
      armed             <= 1'b0;
      cout.data_o       <= '0;
      cout.valid_o      <= 1'b0;
      cout.hold_o       <= '0;
      cout.hold_valid_o <= 1'b0;
      cout.biterr_o     <= 1'b0;
      cout.errcnt_o     <= '0;
      cout.locked_o     <= 1'b0;
      cout.sync_err_o   <= 1'b0;
    end else begin
      sr              <= word[W-IN_WIDTH-1:0];
      phase           <= !cout.enable_i ? '0 : resync ? PW'(1) : cout.locked_o ? phase + 1'b1 : '0;
      cout.locked_o   <= cout.enable_i & (cout.locked_o | cout.sync_i);
      cout.sync_err_o <= resync & cout.locked_o & (phase != '0);
      cout.valid_o    <= done;
      cout.biterr_o   <= miss;
      cout.errcnt_o   <= cout.errcnt_clr_i ? '0 :
                         (miss && !(&cout.errcnt_o)) ? cout.errcnt_o + 1'b1 : cout.errcnt_o;
      if (done) cout.data_o <= word;
      if (done && (armed || cout.capture_i)) begin
        cout.hold_o       <= word;
        cout.hold_valid_o <= 1'b1;
        armed             <= 1'b0;
      end else if (cout.capture_i) begin
        cout.hold_valid_o <= 1'b0;
        armed             <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_surf_cout_word_capture.sv
// tb_surf_cout_word_capture: directed and random stimulus against a queue-based word model
module tb_surf_cout_word_capture;
  localparam logic [31:0] PAT = 32'hA55A6996;
  logic clk = 1'b0, rst = 1'b0;
  logic en = 1'b0, tr = 1'b0;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;

  surf_cout_word_capture_if #(.IN_WIDTH(4), .NBEATS(8), .CNT_WIDTH(16)) bus ();
  surf_cout_word_capture_if #(.IN_WIDTH(4), .NBEATS(8), .CNT_WIDTH(2))  bus2 ();
  assign bus2.sync_i       = bus.sync_i;
  assign bus2.data_i       = bus.data_i;
  assign bus2.enable_i     = bus.enable_i;
  assign bus2.train_i      = bus.train_i;
  assign bus2.capture_i    = bus.capture_i;
  assign bus2.errcnt_clr_i = bus.errcnt_clr_i;

  surf_cout_word_capture #(.IN_WIDTH(4), .NBEATS(8), .TRAIN_PATTERN(PAT), .CNT_WIDTH(16))
    dut (.sysclk_i(clk), .rst_i(rst), .cout(bus));
  surf_cout_word_capture #(.IN_WIDTH(4), .NBEATS(8), .TRAIN_PATTERN(PAT), .CNT_WIDTH(2))
    dut2 (.sysclk_i(clk), .rst_i(rst), .cout(bus2));

  logic [3:0]  q[$];
  logic        m_locked, m_valid, m_biterr, m_serr, m_hv, m_armed;
  logic [31:0] m_data, m_hold;
  int          m_cnt, m_cnt2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    {m_locked, m_valid, m_biterr, m_serr, m_hv, m_armed} = '0;
    m_data = '0; m_hold = '0; m_cnt = 0; m_cnt2 = 0;
  endtask

  task automatic model_tick(input logic s, input logic c, input logic clr, input logic [3:0] d);
    logic done;
    logic [31:0] w;
    done = 1'b0; w = '0;
    m_valid = 1'b0; m_biterr = 1'b0; m_serr = 1'b0;
    if (!en) begin
      m_locked = 1'b0;
      q.delete();
    end else if (s) begin
      m_serr = m_locked && q.size() != 0;
      q.delete();
      q.push_back(d);
      m_locked = 1'b1;
    end else if (m_locked) begin
      q.push_back(d);
      if (q.size() == 8) begin
        done = 1'b1;
        foreach (q[i]) w = (w << 4) | 32'(q[i]);
        q.delete();
      end
    end
    if (done) begin
      m_valid = 1'b1;
      m_data = w;
      m_biterr = tr && w != PAT;
    end
    if (clr) begin
      m_cnt = 0; m_cnt2 = 0;
    end else if (m_biterr) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : m_cnt2;
    end
    if (done && (m_armed || c)) begin
      m_hold = w; m_hv = 1'b1; m_armed = 1'b0;
    end else if (c) begin
      m_armed = 1'b1; m_hv = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("valid", 32'(bus.valid_o), 32'(m_valid));
    chk("data", bus.data_o, m_data);
    chk("biterr", 32'(bus.biterr_o), 32'(m_biterr));
    chk("errcnt", 32'(bus.errcnt_o), m_cnt);
    chk("errcnt_sat", 32'(bus2.errcnt_o), m_cnt2);
    chk("hold", bus.hold_o, m_hold);
    chk("hold_valid", 32'(bus.hold_valid_o), 32'(m_hv));
    chk("locked", 32'(bus.locked_o), 32'(m_locked));
    chk("sync_err", 32'(bus.sync_err_o), 32'(m_serr));
  endtask

  task automatic step(input logic s, input logic c, input logic clr, input logic [3:0] d);
    bus.sync_i = s; bus.capture_i = c; bus.errcnt_clr_i = clr; bus.data_i = d;
    bus.enable_i = en; bus.train_i = tr;
    @(posedge clk);
    model_tick(s, c, clr, d);
    #1;
    check_all();
  endtask

  task automatic send_word(input logic [31:0] w, input logic s, input logic c, input logic clr);
    for (int i = 0; i < 8; i++)
      step(s && i == 0, c && i == 7, clr && i == 7, w[31-4*i -: 4]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] bad;
    bus.sync_i = 0; bus.capture_i = 0; bus.errcnt_clr_i = 0; bus.data_i = 0;
    bus.enable_i = 0; bus.train_i = 0;
    model_reset();
    @(negedge clk);
    do_reset();
    en = 1'b1; tr = 1'b1;
    repeat (9) step(0, 0, 0, 4'h0);
    for (int i = 0; i < 7; i++) begin
      step(i == 0, 0, 0, PAT[31-4*i -: 4]);
      chk("no_early_valid", 32'(bus.valid_o), 0);
    end
    step(0, 0, 0, PAT[3:0]);
    chk("first_valid", 32'(bus.valid_o), 1);
    chk("first_word", bus.data_o, PAT);
    chk("first_biterr", 32'(bus.biterr_o), 0);
    step(0, 0, 0, 4'h3);
    chk("no_back_to_back", 32'(bus.valid_o), 0);
    send_word(PAT, 1, 0, 0);
    bad = PAT ^ 32'h0001_0000;
    repeat (5) send_word(bad, 0, 0, 0);
    chk("errcnt5", 32'(bus.errcnt_o), 5);
    chk("errcnt_sat3", 32'(bus2.errcnt_o), 3);
    send_word(bad, 0, 0, 1);
    chk("clr_beats_err", 32'(bus.errcnt_o), 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h1);
    step(1, 0, 0, PAT[31:28]);
    chk("resync_p3_err", 32'(bus.sync_err_o), 1);
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0, PAT[31-4*i -: 4]);
      chk("trunc_not_emitted", 32'(bus.valid_o), i == 7 ? 1 : 0);
    end
    chk("resync_word", bus.data_o, PAT);
    step(1, 0, 0, 4'h7);
    chk("resync_p0_silent", 32'(bus.sync_err_o), 0);
    for (int i = 1; i < 8; i++) step(0, 0, 0, 4'h7);
    send_word(32'h1234_5678, 0, 1, 0);
    chk("cap_hold", bus.hold_o, 32'h1234_5678);
    chk("cap_hv", 32'(bus.hold_valid_o), 1);
    send_word(32'h9ABC_DEF0, 0, 0, 0);
    chk("no_overwrite", bus.hold_o, 32'h1234_5678);
    step(0, 1, 0, 4'hC);
    chk("rearm_clears_hv", 32'(bus.hold_valid_o), 0);
    for (int i = 1; i < 8; i++) step(0, 0, 0, 4'hC);
    chk("rearm_load", bus.hold_o, 32'hCCCC_CCCC);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 4'h5);
    en = 1'b0;
    step(0, 0, 0, 4'h5);
    chk("disable_unlock", 32'(bus.locked_o), 0);
    en = 1'b1;
    repeat (10) step(0, 0, 0, 4'h5);
    send_word(PAT, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 4'h2);
    do_reset();
    chk("rst_unlock", 32'(bus.locked_o), 0);
    repeat (10) step(0, 0, 0, 4'h2);
    send_word(PAT, 1, 0, 0);
    chk("resume_after_sync", bus.data_o, PAT);
    for (int n = 0; n < 4000; n++) begin
      logic [3:0] d;
      en = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 199) == 0) tr = ~tr;
      d = ($urandom_range(0, 3) != 0 && q.size() < 8) ? PAT[31-4*q.size() -: 4] : 4'($urandom);
      step($urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0,
           $urandom_range(0, 49) == 0, d);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
